// File: rtl/pulse_gen_pkg.sv
// Shared types and width helper for the multi-channel pulse generator.
// Optional one-shot support is enabled by defining PULSE_GEN_ONESHOT_EN.
package pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // Channel-select width; never narrower than one bit.
    function automatic int chw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_gen_chan.sv
// One independent pulse channel: counter, active and shadow config.
// One-shot mode and trigger exist only with PULSE_GEN_ONESHOT_EN defined.
module pulse_gen_chan import pulse_gen_pkg::*; #(
    parameter int              SIZE      = 16,
    parameter logic [SIZE-1:0] DEF_LIMIT = 16'd9600,
    parameter logic [SIZE-1:0] DEF_WIDTH = 16'd1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_trig,
    input  logic            i_we,
    input  logic [SIZE-1:0] i_limit,
    input  logic [SIZE-1:0] i_width,
    input  logic            i_oneshot,
    output logic            o_pulse,
    output logic            o_tc,
    output logic            o_busy
);

    state_e          r_state;
    logic [SIZE-1:0] r_count;
    logic [SIZE-1:0] r_lim;
    logic [SIZE-1:0] r_wid;
    mode_e           r_mode;
    logic [SIZE-1:0] r_sh_lim;
    logic [SIZE-1:0] r_sh_wid;
    mode_e           r_sh_mode;
    logic            r_pulse;
    logic            r_tc;

    state_e          w_nxt_state;
    logic [SIZE-1:0] w_nxt_count;
    logic [SIZE-1:0] w_sh_lim_d;
    logic [SIZE-1:0] w_sh_wid_d;
    mode_e           w_sh_mode_d;
    logic            w_at_tc;
    logic            w_start;
    logic            w_apply;
    logic            w_pulse_d;
    logic            w_tc_d;

`ifdef PULSE_GEN_ONESHOT_EN
    assign w_sh_mode_d = i_we ? mode_e'(i_oneshot) : r_sh_mode;
    assign w_start     = i_en & ((r_mode == MODE_PERIODIC) | i_trig);
`else
    logic w_unused;
    assign w_unused    = ^{i_trig, i_oneshot};
    assign w_sh_mode_d = MODE_PERIODIC;
    assign w_start     = i_en;
`endif

    // Next state, next count, shadow update and registered-output inputs.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_at_tc     = (r_state == ST_RUN) && (r_count == r_lim);
        w_pulse_d   = (r_state == ST_RUN) && (r_count < r_wid);
        w_tc_d      = w_at_tc;
        w_sh_lim_d  = i_we ? i_limit : r_sh_lim;
        w_sh_wid_d  = i_we ? i_width : r_sh_wid;
        // New config reaches the active set only between periods.
        w_apply     = (r_state == ST_IDLE) || w_at_tc;
        unique case (r_state)
            ST_IDLE: begin
                w_nxt_count = '0;
                if (w_start) w_nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (!i_en || (r_mode == MODE_ONESHOT && w_at_tc)) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_count = '0;
                end else if (w_at_tc) begin
                    w_nxt_count = '0;
                end else begin
                    w_nxt_count = r_count + 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_count = '0;
            end
        endcase
    end

    // State, counter, config and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_lim     <= DEF_LIMIT;
            r_wid     <= DEF_WIDTH;
            r_mode    <= MODE_PERIODIC;
            r_sh_lim  <= DEF_LIMIT;
            r_sh_wid  <= DEF_WIDTH;
            r_sh_mode <= MODE_PERIODIC;
            r_pulse   <= 1'b0;
            r_tc      <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_count   <= w_nxt_count;
            r_sh_lim  <= w_sh_lim_d;
            r_sh_wid  <= w_sh_wid_d;
            r_sh_mode <= w_sh_mode_d;
            r_pulse   <= w_pulse_d;
            r_tc      <= w_tc_d;
            if (w_apply) begin
                r_lim  <= w_sh_lim_d;
                r_wid  <= w_sh_wid_d;
                r_mode <= w_sh_mode_d;
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_tc    = r_tc;
    assign o_busy  = (r_state == ST_RUN);

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel pulse generator top: config decode plus channel array.
// Define PULSE_GEN_ONESHOT_EN to honour cfg_oneshot and trig.
module pulse_gen import pulse_gen_pkg::*; #(
    parameter int              SIZE      = 16,
    parameter int              NCH       = 2,
    parameter logic [SIZE-1:0] DEF_LIMIT = 16'd9600,
    parameter logic [SIZE-1:0] DEF_WIDTH = 16'd1,
    localparam int             CHW       = chw(NCH)
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic [NCH-1:0]  en,
    input  logic [NCH-1:0]  trig,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [SIZE-1:0] cfg_limit,
    input  logic [SIZE-1:0] cfg_width,
    input  logic            cfg_oneshot,
    output logic [NCH-1:0]  pulse,
    output logic [NCH-1:0]  tc,
    output logic [NCH-1:0]  busy
);

    logic [NCH-1:0] w_we;

    // Route the write strobe to one channel; out-of-range selects hit none.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && (cfg_ch == CHW'(i))) w_we[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pulse_gen_chan #(
            .SIZE      (SIZE),
            .DEF_LIMIT (DEF_LIMIT),
            .DEF_WIDTH (DEF_WIDTH)
        ) u_chan (
            .i_clk     (clk_in),
            .i_rst     (rst),
            .i_en      (en[g]),
            .i_trig    (trig[g]),
            .i_we      (w_we[g]),
            .i_limit   (cfg_limit),
            .i_width   (cfg_width),
            .i_oneshot (cfg_oneshot),
            .o_pulse   (pulse[g]),
            .o_tc      (tc[g]),
            .o_busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen (default build, periodic channels).
// Directed scenarios followed by randomized traffic.
module tb_pulse_gen;

    localparam int NCH  = 2;
    localparam int DLIM = 9600;
    localparam int DWID = 1;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  en = '0;
    logic [1:0]  trig = '0;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_ch = '0;
    logic [15:0] cfg_limit = '0;
    logic [15:0] cfg_width = '0;
    logic        cfg_oneshot = 1'b0;
    logic [1:0]  pulse;
    logic [1:0]  tc;
    logic [1:0]  busy;

    pulse_gen dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .trig        (trig),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_limit   (cfg_limit),
        .cfg_width   (cfg_width),
        .cfg_oneshot (cfg_oneshot),
        .pulse       (pulse),
        .tc          (tc),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0] p;
        logic [1:0] t;
        logic [1:0] b;
    } exp_s;

    exp_s sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference: per channel a running flag, position within the current
    // period, the parameters of that period and the latest written values.
    bit m_run[NCH];
    int m_pos[NCH];
    int m_lim[NCH];
    int m_wid[NCH];
    int s_lim[NCH];
    int s_wid[NCH];

    task automatic check(input string nm, input logic [1:0] act,
                         input logic [1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", nm, act, req, $time);
    endtask

    task automatic model(input logic r, input logic [1:0] e,
                         input logic w, input int ch, input int lim,
                         input int wid);
        exp_s x;
        x.p = '0;
        x.t = '0;
        x.b = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r) begin
                m_run[c] = 0;
                m_pos[c] = 0;
                m_lim[c] = DLIM;
                m_wid[c] = DWID;
                s_lim[c] = DLIM;
                s_wid[c] = DWID;
            end else begin
                bit last;
                last = m_run[c] && (m_pos[c] == m_lim[c]);
                x.p[c] = m_run[c] && (m_pos[c] < m_wid[c]);
                x.t[c] = last;
                if (w && ch == c) begin
                    s_lim[c] = lim;
                    s_wid[c] = wid;
                end
                if (!m_run[c] || last) begin
                    m_lim[c] = s_lim[c];
                    m_wid[c] = s_wid[c];
                end
                if (!m_run[c]) begin
                    m_run[c] = e[c];
                    m_pos[c] = 0;
                end else if (!e[c]) begin
                    m_run[c] = 0;
                    m_pos[c] = 0;
                end else begin
                    m_pos[c] = last ? 0 : m_pos[c] + 1;
                end
                x.b[c] = m_run[c];
            end
        end
        sb.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic [1:0] e,
                       input logic [1:0] tg, input logic w, input int ch,
                       input int lim, input int wid, input logic os);
        @(negedge clk_in);
        rst         = r;
        en          = e;
        trig        = tg;
        cfg_we      = w;
        cfg_ch      = 1'(ch);
        cfg_limit   = 16'(lim);
        cfg_width   = 16'(wid);
        cfg_oneshot = os;
        model(r, e, w, ch, lim, wid);
    endtask

    task automatic idle(input logic [1:0] e, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, e, 2'b00, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] e, input int ch, input int lim,
                      input int wid);
        cyc(1'b0, e, 2'b00, 1'b1, ch, lim, wid, 1'b0);
    endtask

    // Monitor: each cycle with a pending expectation is compared.
    always @(posedge clk_in) begin
        #1;
        if (sb.size() > 0) begin
            exp_s x;
            x = sb.pop_front();
            check("pulse", pulse, x.p);
            check("tc", tc, x.t);
            check("busy", busy, x.b);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0, 1'b0);

        // Default period on channel 0, two full periods.
        idle(2'b01, 2 * (DLIM + 1) + 20);
        idle(2'b00, 2);

        // Channel 1 reconfigured while idle: 11000 pattern.
        wr(2'b00, 1, 4, 2);
        idle(2'b10, 16);
        idle(2'b00, 2);

        // Running reconfiguration takes effect on the next period.
        wr(2'b00, 0, 9, 3);
        idle(2'b01, 6);
        wr(2'b01, 0, 3, 3);
        idle(2'b01, 24);
        idle(2'b00, 2);

        // Width zero and width beyond limit.
        wr(2'b00, 0, 9, 0);
        wr(2'b00, 1, 5, 20);
        idle(2'b11, 22);
        idle(2'b00, 2);

        // Limit zero: tc every cycle.
        wr(2'b00, 0, 0, 1);
        idle(2'b01, 6);
        idle(2'b00, 2);

        // Reset mid-run with a competing write, then default period again.
        wr(2'b00, 0, 9, 3);
        idle(2'b01, 4);
        cyc(1'b1, 2'b11, 2'b11, 1'b1, 0, 2, 2, 1'b1);
        idle(2'b01, DLIM + 4);
        idle(2'b00, 2);

        // Randomized traffic with short periods.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] e;
            logic       w;
            logic       os;
            r = ($urandom_range(0, 199) == 0);
            e[0] = ($urandom_range(0, 7) != 0);
            e[1] = ($urandom_range(0, 7) != 0);
            w = ($urandom_range(0, 7) == 0);
`ifdef PULSE_GEN_ONESHOT_EN
            os = 1'b0;
`else
            os = 1'($urandom_range(0, 1));
`endif
            cyc(r, e, 2'($urandom_range(0, 3)), w, $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 9), os);
        end
        idle(2'b00, 2);

        repeat (3) @(posedge clk_in);
        #2;
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SIZE, 16, counter/limit/width bit width.
REQ-002 NCH, 2, number of independent channels (1..8).
REQ-003 DEF_LIMIT, 16'd9600, per-channel terminal count after reset (period = LIMIT+1 cycles).
REQ-004 DEF_WIDTH, 16'd1, per-channel pulse width after reset, in cycles.
REQ-005 clk_in  in  1  sole clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  NCH  per-channel run enable, level-sensitive.
REQ-008 trig  in  NCH  per-channel one-shot start, sampled per cycle.
REQ-009 cfg_we  in  1  config write strobe, one cycle.
REQ-010 cfg_ch  in  CHW=max(1,clog2(NCH))  target channel of write.
REQ-011 cfg_limit  in  SIZE  new terminal count.
REQ-012 cfg_width  in  SIZE  new pulse width.
REQ-013 cfg_oneshot  in  1  new mode: 0 periodic, 1 one-shot.
REQ-014 pulse  out  NCH  registered pulse per channel.
REQ-015 tc  out  NCH  registered one-cycle terminal-count strobe.
REQ-016 busy  out  NCH  channel in RUN state.

Function
REQ-017 Each channel SHALL have states IDLE and RUN plus count, active limit/width/mode, and shadow limit/width/mode.
REQ-018 Periodic mode: IDLE->RUN when en=1; RUN->IDLE on the cycle after en=0, count cleared to 0.
REQ-019 One-shot mode: IDLE->RUN when en=1 and trig=1; RUN->IDLE after the cycle in which count==limit; trig in RUN ignored.
REQ-020 In RUN, count SHALL increment by 1 per cycle, and wrap to 0 in the cycle after count==limit; no other wrap (modular overflow is impossible).
REQ-021 pulse[i] SHALL be 1 in cycle t+1 iff channel in RUN at t and count(t) < width; else 0.
REQ-022 width=0: pulse never asserts; width>limit: pulse held high throughout RUN.
REQ-023 limit=0: period of 1 cycle, tc high every cycle while RUN.
REQ-024 tc[i] SHALL be 1 in cycle t+1 iff channel in RUN and count(t)==limit.
REQ-025 cfg_we with cfg_ch>=NCH SHALL be ignored.
REQ-026 cfg_we SHALL write the shadow registers; shadow copies to active immediately if channel is IDLE, otherwise at the cycle count==limit (applies from the next period).
REQ-027 cfg_we coinciding with count==limit SHALL apply the new values to the next period.
REQ-028 Channels SHALL be fully independent; no cross-channel timing interaction.

Reset
REQ-029 rst=1 SHALL, on the clock edge, force all channels to IDLE, count=0, pulse=0, tc=0, busy=0, active and shadow limit=DEF_LIMIT, width=DEF_WIDTH, mode=periodic.
REQ-030 rst SHALL dominate en, trig, cfg_we in the same cycle; mid-run reset aborts the period with no trailing tc.

Configuration
REQ-031 Macro PULSE_GEN_ONESHOT_EN: defined -> one-shot mode and trig honored per REQ-019.
REQ-032 Not defined -> cfg_oneshot and trig ignored, every channel periodic only, trig port retained but unused.

Structure
REQ-033 Package pulse_gen_pkg SHALL hold the state enum (IDLE, RUN), the mode enum (periodic, one-shot) and the CHW derivation function.
REQ-034 Per-channel logic SHALL live in sub-module pulse_gen_chan, instantiated NCH times by a generate loop; top contains only config decode.

Verification
REQ-035 SIZE=16, defaults, en[0]=1 held: pulse[0] high 1 cycle every 9601 cycles, tc[0] aligned with count==9600.
REQ-036 Write ch1 limit=4 width=2 while IDLE, en[1]=1: pulse[1] pattern 11000 repeating, tc[1] every 5 cycles.
REQ-037 Ch0 running limit=9 width=3, write limit=3 at count=5: current period completes at 10 cycles, subsequent periods are 4 cycles.
REQ-038 With PULSE_GEN_ONESHOT_EN, ch0 one-shot limit=7 width=8, trig pulse: pulse high 8 cycles, single tc, busy falls, repeat trig mid-run ignored.
REQ-039 Ch0 width=0 and ch1 width=20 limit=5: pulse[0] stays 0, pulse[1] stays 1 while RUN.
REQ-040 rst asserted at count=3 with cfg_we present: next cycle all outputs 0, limit=9600, no tc emitted.
